// File: rtl/mult_pkg.sv
// Shared encodings for the sequential 8x8 multiplier controller and datapath.
package mult_pkg;

    localparam int unsigned CNT_W = 2;

    // Partial-product operand select: {a nibble, b nibble}, 0 = low, 1 = high.
    localparam logic [1:0] SEL_LL = 2'b00;
    localparam logic [1:0] SEL_LH = 2'b01;
    localparam logic [1:0] SEL_HL = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    // Partial-product shift select; 2'b11 is reserved and adds unshifted.
    localparam logic [1:0] SH_0  = 2'b00;
    localparam logic [1:0] SH_H  = 2'b01;
    localparam logic [1:0] SH_2H = 2'b10;

endpackage

// File: rtl/mult_datapath_if.sv
// Controller <-> datapath bundle: the controller drives commands, the datapath returns state.
interface mult_datapath_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0]          dataa;
    logic [DATA_W-1:0]          datab;
    logic [1:0]                 input_sel;
    logic [1:0]                 shift_sel;
    logic                       clk_ena;
    logic                       sclr_n;
    logic [mult_pkg::CNT_W-1:0] count;
    logic [2*DATA_W-1:0]        product;
    logic [DATA_W-1:0]          a_q;
    logic [DATA_W-1:0]          b_q;

    modport master (
        output dataa, datab, input_sel, shift_sel, clk_ena, sclr_n,
        input  count, product, a_q, b_q
    );

    modport slave (
        input  dataa, datab, input_sel, shift_sel, clk_ena, sclr_n,
        output count, product, a_q, b_q
    );

endinterface

// File: rtl/mult4x4.sv
// Combinational unsigned H x H -> 2H multiplier for one partial product.
module mult4x4 #(
    parameter int unsigned H = 4
) (
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-1:0] p_o
);

    assign p_o = (2*H)'(a_i) * (2*H)'(b_i);

endmodule

// File: rtl/mult_datapath.sv
// Multiplier datapath: captures operands on clear, then accumulates four shifted
// nibble partial products under controller command.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset_a,
    mult_datapath_if.slave bus
);

    localparam int unsigned H  = DATA_W / 2;
    localparam int unsigned PW = 2 * DATA_W;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PW-1:0]     product_q, product_d;
    logic [DATA_W-1:0] a_reg_q, a_reg_d;
    logic [DATA_W-1:0] b_reg_q, b_reg_d;

    logic [H-1:0]   nib_a, nib_b;
    logic [2*H-1:0] pp;
    logic [PW-1:0]  addend;

    always_comb begin
        nib_a = a_reg_q[H-1:0];
        nib_b = b_reg_q[H-1:0];
        case (bus.input_sel)
            SEL_LL: begin nib_a = a_reg_q[H-1:0];   nib_b = b_reg_q[H-1:0];   end
            SEL_LH: begin nib_a = a_reg_q[H-1:0];   nib_b = b_reg_q[2*H-1:H]; end
            SEL_HL: begin nib_a = a_reg_q[2*H-1:H]; nib_b = b_reg_q[H-1:0];   end
            default: begin nib_a = a_reg_q[2*H-1:H]; nib_b = b_reg_q[2*H-1:H]; end
        endcase
    end

    mult4x4 #(
        .H (H)
    ) u_mult4x4 (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (pp)
    );

    always_comb begin
        addend = PW'(pp);
        case (bus.shift_sel)
            SH_H:    addend = PW'(pp) << H;
            SH_2H:   addend = PW'(pp) << (2 * H);
            default: addend = PW'(pp);
        endcase
    end

    // Clear wins over step regardless of clk_ena.
    always_comb begin
        count_d   = count_q;
        product_d = product_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        if (!bus.sclr_n) begin
            count_d   = '0;
            product_d = '0;
            a_reg_d   = bus.dataa;
            b_reg_d   = bus.datab;
        end else if (bus.clk_ena) begin
            count_d   = count_q + CNT_W'(1);
            product_d = product_q + addend;
        end
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            count_q   <= '0;
            product_q <= '0;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
        end else begin
            count_q   <= count_d;
            product_q <= product_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.product = product_q;
    assign bus.a_q     = a_reg_q;
    assign bus.b_q     = b_reg_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed cases plus randomized commands
// compared against an arithmetic model of the accumulator.
module tb_mult_datapath;
    import mult_pkg::*;

    localparam int unsigned DATA_W = 8;

    logic clk     = 1'b0;
    logic reset_a = 1'b0;

    mult_datapath_if #(.DATA_W(DATA_W)) bus ();

    mult_datapath #(
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model state: plain integers, product kept modulo 2^16.
    int unsigned m_a = 0, m_b = 0, m_prod = 0, m_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int unsigned nib(input int unsigned v, input bit hi);
        return hi ? ((v >> 4) & 15) : (v & 15);
    endfunction

    task automatic model_edge(input bit sclr_n, input bit ena, input logic [1:0] isel,
                              input logic [1:0] ssel, input int unsigned a, input int unsigned b);
        int unsigned pp, weight;
        if (!sclr_n) begin
            m_a = a; m_b = b; m_prod = 0; m_cnt = 0;
        end else if (ena) begin
            pp     = nib(m_a, isel[1]) * nib(m_b, isel[0]);
            weight = (ssel == 2'b01) ? 16 : (ssel == 2'b10) ? 256 : 1;
            m_prod = (m_prod + pp * weight) % 65536;
            m_cnt  = (m_cnt + 1) % 4;
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".product"}, 32'(bus.product), m_prod);
        check_eq({tag, ".count"},   32'(bus.count),   m_cnt);
        check_eq({tag, ".a_q"},     32'(bus.a_q),     m_a);
        check_eq({tag, ".b_q"},     32'(bus.b_q),     m_b);
    endtask

    // Called at a negedge; applies one clock of commands and checks just after the edge.
    task automatic drive(input bit sclr_n, input bit ena, input logic [1:0] isel,
                         input logic [1:0] ssel, input int unsigned a, input int unsigned b);
        bus.sclr_n    = sclr_n;
        bus.clk_ena   = ena;
        bus.input_sel = isel;
        bus.shift_sel = ssel;
        bus.dataa     = a[7:0];
        bus.datab     = b[7:0];
        @(posedge clk);
        model_edge(sclr_n, ena, isel, ssel, a, b);
        #1;
        check_model("step");
        @(negedge clk);
    endtask

    // Full controller sequence; operand inputs are scrambled after the clear edge.
    task automatic nominal(input int unsigned a, input int unsigned b);
        drive(1'b0, 1'b1, SEL_LL, SH_0,  a, b);
        drive(1'b1, 1'b1, SEL_LL, SH_0,  $urandom_range(255), $urandom_range(255));
        drive(1'b1, 1'b1, SEL_LH, SH_H,  $urandom_range(255), $urandom_range(255));
        drive(1'b1, 1'b1, SEL_HL, SH_H,  $urandom_range(255), $urandom_range(255));
        drive(1'b1, 1'b1, SEL_HH, SH_2H, $urandom_range(255), $urandom_range(255));
        check_eq("nominal.final", 32'(bus.product), a * b);
        check_eq("nominal.count", 32'(bus.count), 0);
    endtask

    logic [1:0]  sel_tab [4] = '{SEL_LL, SEL_LH, SEL_HL, SEL_HH};
    logic [1:0]  sh_tab  [4] = '{SH_0, SH_H, SH_H, SH_2H};
    int unsigned exp_tab [4] = '{32'h0008, 32'h0068, 32'h00A8, 32'h03A8};

    initial begin
        bus.dataa = '0; bus.datab = '0; bus.input_sel = '0; bus.shift_sel = '0;
        bus.clk_ena = 1'b0; bus.sclr_n = 1'b1;

        #12;
        check_model("reset");
        @(negedge clk);
        reset_a = 1'b1;

        // Directed 0x12 x 0x34 with per-step constants; inputs held steady.
        drive(1'b0, 1'b1, SEL_LL, SH_0, 32'h12, 32'h34);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, sel_tab[i], sh_tab[i], 32'h12, 32'h34);
            check_eq($sformatf("dir.prod%0d", i), 32'(bus.product), exp_tab[i]);
            check_eq($sformatf("dir.cnt%0d", i), 32'(bus.count), (i + 1) % 4);
        end

        nominal(32'h12, 32'h34);
        check_eq("stable.0x3A8", 32'(bus.product), 32'h03A8);
        nominal(32'hFF, 32'hFF);
        check_eq("ffxff", 32'(bus.product), 32'hFE01);
        nominal(32'h00, 32'hAB);
        check_eq("zero", 32'(bus.product), 32'h0000);

        // Hold for three cycles mid-sequence, then clear while clk_ena is low.
        drive(1'b0, 1'b1, SEL_LL, SH_0, 32'h12, 32'h34);
        drive(1'b1, 1'b1, SEL_LL, SH_0, 32'h00, 32'h00);
        drive(1'b1, 1'b1, SEL_LH, SH_H, 32'h00, 32'h00);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, SEL_HH, SH_2H, 32'h55, 32'hAA);
        check_eq("hold.prod", 32'(bus.product), 32'h0068);
        check_eq("hold.cnt", 32'(bus.count), 2);
        drive(1'b0, 1'b0, SEL_LL, SH_0, 32'h9C, 32'h27);
        check_eq("clr_noena.prod", 32'(bus.product), 0);
        check_eq("clr_noena.a", 32'(bus.a_q), 32'h9C);

        // Asynchronous reset between edges after two steps.
        drive(1'b0, 1'b1, SEL_LL, SH_0, 32'h12, 32'h34);
        drive(1'b1, 1'b1, SEL_LL, SH_0, 32'h12, 32'h34);
        drive(1'b1, 1'b1, SEL_LH, SH_H, 32'h12, 32'h34);
        #2 reset_a = 1'b0;
        #1;
        m_a = 0; m_b = 0; m_prod = 0; m_cnt = 0;
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_held");
        @(negedge clk);
        reset_a = 1'b1;
        nominal(32'h0F, 32'hF0);
        check_eq("after_rst", 32'(bus.product), 32'h0E10);

        // Reserved shift adds unshifted, then counter wraps after four steps.
        drive(1'b0, 1'b1, SEL_LL, SH_0, 32'h03, 32'h05);
        drive(1'b1, 1'b1, SEL_LL, 2'b11, 32'h03, 32'h05);
        check_eq("sh11", 32'(bus.product), 32'h000F);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, SEL_LL, SH_0, 32'h03, 32'h05);
        check_eq("wrap", 32'(bus.count), 0);

        // Randomized operands on the nominal sequence.
        for (int i = 0; i < 20; i++) nominal($urandom_range(255), $urandom_range(255));

        // Randomized out-of-sequence commands, including occasional clears.
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(7) != 0), 1'($urandom), 2'($urandom), 2'($urandom),
                  $urandom_range(255), $urandom_range(255));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
